// File: rtl/picosoc_bus_pkg.sv
// Shared definitions for the PicoSoC bus decoder.
//   state_e    : sequencer states (IDLE, ACCESS, RESP, ERR)
//   ERR_RDATA  : read data returned on an error completion
//   idx_width  : width of a slave index for a given slave count
package picosoc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  // A single slave still needs a 1-bit index so the register has a legal width.
  function automatic int idx_width(input int nslv);
    return (nslv > 1) ? $clog2(nslv) : 1;
  endfunction

endpackage

// File: rtl/picosoc_busdec_timer.sv
// Access watchdog counter for picosoc_busdec.
//   clk, reset : clock, synchronous active-high reset
//   clr        : reload the count with zero (has priority over en)
//   en         : count one cycle
//   expired    : the current enabled cycle is the LIMIT-th one
// The count saturates at LIMIT so it never wraps back into the window.
module picosoc_busdec_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = en && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/picosoc_busdec.sv
// N-slave bus decoder/sequencer between the PicoRV32 native memory port and
// the SoC peripherals. Each slave owns a base/mask window; the request is
// registered, forwarded to one slave, and the response registered back.
// Unmapped (and, with the watchdog, hung) accesses complete with an error
// and raise a sticky error flag with the first failing address.
//   m_*      : CPU side (valid/ready handshake, address, write data/strobes)
//   s_*      : slave side (one-hot valid, per-slave ready/rdata, broadcast
//              latched address/wdata/wstrb)
//   err_clr  : clears err_irq
//   err_irq  : sticky error level
//   err_addr : address of the first error since the last clear
// Build option: define PICOSOC_BUSDEC_TIMEOUT_EN to enable the per-access
// watchdog (TIMEOUT_CYCLES); otherwise ACCESS waits for s_ready forever.
module picosoc_busdec
  import picosoc_bus_pkg::*;
#(
  parameter int                   NSLV           = 4,
  parameter logic [32*NSLV-1:0]   SLV_BASE       = {NSLV{32'h0}},
  parameter logic [32*NSLV-1:0]   SLV_MASK       = {NSLV{32'hFFFF_FFFF}},
  parameter int                   TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m_valid,
  output logic                 m_ready,
  input  logic [31:0]          m_addr,
  input  logic [31:0]          m_wdata,
  input  logic [3:0]           m_wstrb,
  output logic [31:0]          m_rdata,
  output logic [NSLV-1:0]      s_valid,
  input  logic [NSLV-1:0]      s_ready,
  input  logic [32*NSLV-1:0]   s_rdata,
  output logic [31:0]          s_addr,
  output logic [31:0]          s_wdata,
  output logic [3:0]           s_wstrb,
  input  logic                 err_clr,
  output logic                 err_irq,
  output logic [31:0]          err_addr
);

  localparam int IW = idx_width(NSLV);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_irq_q, err_irq_d;
  logic [31:0]   err_addr_q, err_addr_d;

  logic          hit;
  logic [IW-1:0] hit_idx;
  logic          tmr_expired;

`ifdef PICOSOC_BUSDEC_TIMEOUT_EN
  // Held clear outside ACCESS, so every access starts counting from zero.
  picosoc_busdec_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_q != ST_ACCESS),
    .en      (state_q == ST_ACCESS),
    .expired (tmr_expired)
  );
`else
  // Without the watchdog an access only ends on s_ready.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign tmr_expired    = 1'b0;
`endif

  // Address decode: the first (lowest-index) matching window wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (!hit && ((m_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every value gets a default before the case, so paths that do not
    // assign it hold the register and no latch is inferred.
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    err_irq_d  = err_irq_q;
    err_addr_d = err_addr_q;

    if (err_clr) err_irq_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (m_valid) begin
          idx_d   = hit_idx;
          addr_d  = m_addr;
          wdata_d = m_wdata;
          wstrb_d = m_wstrb;
          if (hit) begin
            state_d = ST_ACCESS;
          end else begin
            rdata_d = ERR_RDATA;
            state_d = ST_ERR;
          end
        end
      end
      ST_ACCESS: begin
        // Ready beats a simultaneous watchdog expiry.
        if (s_ready[idx_q]) begin
          rdata_d = s_rdata[32*idx_q +: 32];
          state_d = ST_RESP;
        end else if (tmr_expired) begin
          rdata_d = ERR_RDATA;
          state_d = ST_ERR;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        // Setting wins over err_clr; a coincident clear also lets the new
        // address replace the old one.
        err_irq_d = 1'b1;
        if (!err_irq_q || err_clr) err_addr_d = addr_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      err_irq_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      err_irq_q  <= err_irq_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    s_valid = '0;
    if (state_q == ST_ACCESS) s_valid[idx_q] = 1'b1;
  end

  assign m_ready  = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign m_rdata  = rdata_q;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign s_wstrb  = wstrb_q;
  assign err_irq  = err_irq_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_picosoc_busdec.sv
// Directed bench for picosoc_busdec (two slaves, 8-cycle watchdog when the
// PICOSOC_BUSDEC_TIMEOUT_EN build option is set). A second instance with
// overlapping windows and auto-acknowledging slaves checks decode priority.
module tb_picosoc_busdec;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic [1:0]  s_valid;
  logic [1:0]  s_ready;
  logic [31:0] s_rdata0, s_rdata1;
  logic [63:0] s_rdata;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        err_clr;
  logic        err_irq;
  logic [31:0] err_addr;

  // Overlap instance
  logic        m_valid2;
  logic [31:0] m_addr2;
  logic        m_ready2;
  logic [31:0] m_rdata2;
  logic [1:0]  s_valid2;
  logic [1:0]  s_ready2;
  logic [63:0] s_rdata2;
  logic [31:0] s_addr2, s_wdata2, err_addr2;
  logic [3:0]  s_wstrb2;
  logic        err_irq2;

  int total = 0;
  int bad   = 0;

  assign s_rdata  = {s_rdata1, s_rdata0};
  assign s_ready2 = s_valid2;
  assign s_rdata2 = {32'h0000_0B0B, 32'h0000_0A0A};

  always #5 clk = ~clk;

  picosoc_busdec #(
    .NSLV           (2),
    .SLV_BASE       ({32'h0200_0000, 32'h0000_0000}),
    .SLV_MASK       ({32'hFF00_0000, 32'hFFFF_FC00}),
    .TIMEOUT_CYCLES (8)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_rdata  (m_rdata),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .err_clr  (err_clr),
    .err_irq  (err_irq),
    .err_addr (err_addr)
  );

  picosoc_busdec #(
    .NSLV           (2),
    .SLV_BASE       ({32'h0000_0000, 32'h0000_0000}),
    .SLV_MASK       ({32'hFF00_0000, 32'hFFFF_FC00}),
    .TIMEOUT_CYCLES (8)
  ) u_dut_ovl (
    .clk      (clk),
    .reset    (reset),
    .m_valid  (m_valid2),
    .m_ready  (m_ready2),
    .m_addr   (m_addr2),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_rdata  (m_rdata2),
    .s_valid  (s_valid2),
    .s_ready  (s_ready2),
    .s_rdata  (s_rdata2),
    .s_addr   (s_addr2),
    .s_wdata  (s_wdata2),
    .s_wstrb  (s_wstrb2),
    .err_clr  (err_clr),
    .err_irq  (err_irq2),
    .err_addr (err_addr2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    m_valid  = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
    s_ready  = '0;
    s_rdata0 = '0;
    s_rdata1 = '0;
    err_clr  = 1'b0;
    m_valid2 = 1'b0;
    m_addr2  = '0;
    tick();
    tick();

    // Reset state
    check("rst_m_ready",  {31'h0, m_ready}, 32'h0);
    check("rst_m_rdata",  m_rdata,          32'h0);
    check("rst_s_valid",  {30'h0, s_valid}, 32'h0);
    check("rst_s_addr",   s_addr,           32'h0);
    check("rst_s_wdata",  s_wdata,          32'h0);
    check("rst_s_wstrb",  {28'h0, s_wstrb}, 32'h0);
    check("rst_err_irq",  {31'h0, err_irq}, 32'h0);
    check("rst_err_addr", err_addr,         32'h0);
    reset = 1'b0;

    // Zero-wait read from slave0
    s_rdata0 = 32'h1234_5678;
    s_ready  = 2'b01;
    m_addr   = 32'h0000_0010;
    m_wstrb  = 4'h0;
    m_valid  = 1'b1;
    tick();
    check("rd0_s_valid", {30'h0, s_valid}, 32'h1);
    check("rd0_no_rdy",  {31'h0, m_ready}, 32'h0);
    check("rd0_s_addr",  s_addr,           32'h0000_0010);
    tick();
    check("rd0_m_ready", {31'h0, m_ready}, 32'h1);
    check("rd0_m_rdata", m_rdata,          32'h1234_5678);
    check("rd0_s_off",   {30'h0, s_valid}, 32'h0);
    m_valid = 1'b0;
    s_ready = 2'b00;
    tick();
    check("rd0_pulse",   {31'h0, m_ready}, 32'h0);

    // Write to slave1 with 3 wait cycles; slave0 ready is noise
    s_rdata1 = 32'hCAFE_F00D;
    m_addr   = 32'h0200_0004;
    m_wdata  = 32'hA5A5_5A5A;
    m_wstrb  = 4'hF;
    m_valid  = 1'b1;
    tick();
    s_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      check("wr_s_valid", {30'h0, s_valid}, 32'h2);
      check("wr_wait",    {31'h0, m_ready}, 32'h0);
      check("wr_s_wdata", s_wdata,          32'hA5A5_5A5A);
      check("wr_s_wstrb", {28'h0, s_wstrb}, 32'hF);
      tick();
    end
    check("wr_c4_s_valid", {30'h0, s_valid}, 32'h2);
    s_ready = 2'b10;
    tick();
    check("wr_m_ready", {31'h0, m_ready}, 32'h1);
    check("wr_m_rdata", m_rdata,          32'hCAFE_F00D);
    check("wr_err_irq", {31'h0, err_irq}, 32'h0);
    m_valid = 1'b0;
    m_wstrb = 4'h0;
    s_ready = 2'b00;
    tick();

`ifdef PICOSOC_BUSDEC_TIMEOUT_EN
    // Slave never readies: 8 cycles of s_valid, then error completion
    m_addr  = 32'h0000_0020;
    m_valid = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("to_s_valid", {30'h0, s_valid}, 32'h1);
      check("to_wait",    {31'h0, m_ready}, 32'h0);
      tick();
    end
    check("to_s_off",   {30'h0, s_valid}, 32'h0);
    check("to_m_ready", {31'h0, m_ready}, 32'h1);
    check("to_m_rdata", m_rdata,          32'h0);
    m_valid = 1'b0;
    tick();
    check("to_err_irq",  {31'h0, err_irq}, 32'h1);
    check("to_err_addr", err_addr,         32'h0000_0020);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_clr", {31'h0, err_irq}, 32'h0);

    // Ready on the expiry cycle wins
    s_rdata0 = 32'h55AA_1234;
    m_addr   = 32'h0000_0024;
    m_valid  = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("toe_s_valid", {30'h0, s_valid}, 32'h1);
    s_ready = 2'b01;
    tick();
    check("toe_m_ready", {31'h0, m_ready}, 32'h1);
    check("toe_m_rdata", m_rdata,          32'h55AA_1234);
    m_valid = 1'b0;
    s_ready = 2'b00;
    tick();
    check("toe_no_err", {31'h0, err_irq}, 32'h0);
`else
    // No watchdog: a slow slave is waited on indefinitely
    s_rdata0 = 32'h55AA_1234;
    m_addr   = 32'h0000_0020;
    m_valid  = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      check("nto_s_valid", {30'h0, s_valid}, 32'h1);
      check("nto_wait",    {31'h0, m_ready}, 32'h0);
      tick();
    end
    s_ready = 2'b01;
    tick();
    check("nto_m_ready", {31'h0, m_ready}, 32'h1);
    check("nto_m_rdata", m_rdata,          32'h55AA_1234);
    m_valid = 1'b0;
    s_ready = 2'b00;
    tick();
    check("nto_no_err", {31'h0, err_irq}, 32'h0);
`endif

    // Unmapped read: completes at T+1 with error
    m_addr  = 32'h0400_0000;
    m_valid = 1'b1;
    tick();
    check("um_m_ready", {31'h0, m_ready}, 32'h1);
    check("um_m_rdata", m_rdata,          32'h0);
    check("um_s_valid", {30'h0, s_valid}, 32'h0);
    m_valid = 1'b0;
    tick();
    check("um_err_irq",  {31'h0, err_irq}, 32'h1);
    check("um_err_addr", err_addr,         32'h0400_0000);
    check("um_pulse",    {31'h0, m_ready}, 32'h0);

    // Second error keeps the first address
    m_addr  = 32'h0500_0000;
    m_valid = 1'b1;
    tick();
    check("um2_m_ready", {31'h0, m_ready}, 32'h1);
    m_valid = 1'b0;
    tick();
    check("um2_err_irq",  {31'h0, err_irq}, 32'h1);
    check("um2_err_addr", err_addr,         32'h0400_0000);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("um_clr", {31'h0, err_irq}, 32'h0);

    // After a clear the next error address is captured
    m_addr  = 32'h0600_0000;
    m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    tick();
    check("um3_err_addr", err_addr, 32'h0600_0000);

    // Clear coincident with a new error: set wins, new address taken
    m_addr  = 32'h0700_0000;
    m_valid = 1'b1;
    tick();
    check("um4_m_ready", {31'h0, m_ready}, 32'h1);
    err_clr = 1'b1;
    m_valid = 1'b0;
    tick();
    err_clr = 1'b0;
    check("um4_err_irq",  {31'h0, err_irq}, 32'h1);
    check("um4_err_addr", err_addr,         32'h0700_0000);

    // Overlapping windows: lowest index wins
    m_addr2  = 32'h0000_0010;
    m_valid2 = 1'b1;
    tick();
    check("ovl_s_valid", {30'h0, s_valid2}, 32'h1);
    tick();
    check("ovl_m_ready", {31'h0, m_ready2}, 32'h1);
    check("ovl_m_rdata", m_rdata2,          32'h0000_0A0A);
    m_valid2 = 1'b0;
    tick();

    // Reset during ACCESS aborts without m_ready
    m_addr  = 32'h0000_0030;
    m_wdata = 32'h1111_2222;
    m_wstrb = 4'h3;
    m_valid = 1'b1;
    tick();
    check("ra_s_valid", {30'h0, s_valid}, 32'h1);
    reset   = 1'b1;
    m_valid = 1'b0;
    m_wstrb = 4'h0;
    tick();
    check("ra_m_ready",  {31'h0, m_ready}, 32'h0);
    check("ra_s_valid0", {30'h0, s_valid}, 32'h0);
    check("ra_s_addr",   s_addr,           32'h0);
    check("ra_s_wdata",  s_wdata,          32'h0);
    check("ra_s_wstrb",  {28'h0, s_wstrb}, 32'h0);
    check("ra_err_irq",  {31'h0, err_irq}, 32'h0);
    check("ra_err_addr", err_addr,         32'h0);
    reset = 1'b0;
    tick();
    check("ra_no_ready", {31'h0, m_ready}, 32'h0);

    // Back-to-back reads
    s_ready  = 2'b01;
    s_rdata0 = 32'h1111_2222;
    m_addr   = 32'h0000_0010;
    m_valid  = 1'b1;
    tick();
    tick();
    check("bb1_m_ready", {31'h0, m_ready}, 32'h1);
    check("bb1_m_rdata", m_rdata,          32'h1111_2222);
    m_addr   = 32'h0000_0014;
    s_rdata0 = 32'h3333_4444;
    tick();
    check("bb_idle", {31'h0, m_ready}, 32'h0);
    tick();
    check("bb2_s_addr",  s_addr,           32'h0000_0014);
    check("bb2_s_valid", {30'h0, s_valid}, 32'h1);
    tick();
    check("bb2_m_ready", {31'h0, m_ready}, 32'h1);
    check("bb2_m_rdata", m_rdata,          32'h3333_4444);
    m_valid = 1'b0;
    s_ready = 2'b00;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
